seg7_run_ctrl: RTL and testbench
================================

Name: seg7_run_ctrl

Overview:
Sequencing controller that owns the 32-bit, 8-nibble display word feeding SEG7_LUT_8.iDIG. It replaces the constant all-zero digit word.
- Runs an 8-digit BCD up-counter or a digit-rotate (marquee) pattern, advanced by an internal prescaler tick.
- Run/pause is controlled by a debounced push-button.
- Accepts host preloads through a valid/ready handshake.

Parameters:
- TICK_DIV, 50_000_000, iCLK cycles per display step (>=2). Default gives 1 step/s at 50 MHz.
- DEB_CYC, 1_000_000, consecutive stable cycles before a key level is accepted (20 ms at 50 MHz; >=2).

Ports:
- iCLK  in  1  system clock, CLOCK_50 domain
- iRST_N  in  1  asynchronous active-low reset
- iKEY_PAUSE  in  1  raw active-low push-button, asynchronous to iCLK
- iSTART  in  1  one-cycle pulse, IDLE->RUN
- iCLR  in  1  synchronous clear, highest priority
- iMODE  in  1  0 = BCD count up, 1 = rotate left one digit
- iLOAD_VALID  in  1  preload request
- iLOAD_DATA  in  32  preload word, nibble 7 = HEX7 ... nibble 0 = HEX0
- oLOAD_READY  out  1  preload can be accepted this cycle
- oDIG  out  32  display word to SEG7_LUT_8.iDIG
- oRUNNING  out  1  state == RUN
- oTICK  out  1  one-cycle pulse on each display step
- oWRAP  out  1  one-cycle pulse on count rollover or full rotation

Behaviour:
- Reset (async assert, sync release): state IDLE, oDIG=0, prescaler=0, rotate count=0, debouncer level=1 (released), all pulse outputs 0.
- FSM has three states: IDLE, RUN, PAUSE.
  - IDLE -> RUN on iSTART.
  - RUN <-> PAUSE on each debounced press event.
  - iSTART is ignored outside IDLE.
  - Press events in IDLE are ignored.
- iCLR (any state): oDIG=0, prescaler=0, rotate count=0, state IDLE, any load ignored. Takes effect the next edge.
- Key path:
  - 2-flop synchronizer feeds a stability counter.
  - Accepted level updates after DEB_CYC consecutive equal samples.
  - A press event is a 1->0 transition of the accepted level.
  - Bounces shorter than DEB_CYC produce no event.
- Prescaler:
  - Counts only in RUN.
  - When it reaches TICK_DIV-1 it wraps to 0 and oTICK=1 for that cycle.
  - It holds its value in PAUSE, so the step period is preserved across a pause.
- Step on tick, BCD mode (iMODE=0):
  - Ripple +1 from nibble 0.
  - A nibble >=9 with carry-in becomes 0 and passes the carry on; otherwise it increments and the carry stops.
  - 0x99999999 -> 0x00000000 asserts oWRAP with the tick.
  - Non-BCD loaded nibbles (A-F) therefore self-correct on the first carry into them.
- Step on tick, rotate mode (iMODE=1):
  - oDIG <= {oDIG[27:0], oDIG[31:28]}.
  - The 3-bit rotate count increments; oWRAP asserts when it wraps 7->0.
- iMODE is sampled only on tick cycles. Any iMODE change clears the rotate count.
- Handshake:
  - oLOAD_READY = (state IDLE or PAUSE) and !iCLR.
  - Transfer occurs when iLOAD_VALID && oLOAD_READY: oDIG <= iLOAD_DATA, prescaler=0, rotate count=0, state unchanged.
  - In RUN, VALID is held off. There is no buffering, and the host must hold VALID until ready.
- Same-cycle priority: iCLR > load > press event > tick.
  - Load plus press in PAUSE: the data loads and the state goes to RUN. The first step occurs TICK_DIV cycles later.
  - Press in RUN on a tick cycle: the tick step is still applied, then the state goes to PAUSE.
- Output timing:
  - All outputs are registered except oLOAD_READY (combinational from state/iCLR) and oRUNNING.
  - oDIG changes one cycle after the tick or load event.

Decomposition:
- Shared include seg7_ctrl_defs.vh holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2
  - mode codes MODE_BCD=1'b0, MODE_ROT=1'b1
  - NIB_W=4 and NUM_DIG=8
- One sub-module, seg7_key_debounce: synchronizer, stability counter and press-event output. Parameter DEB_CYC; ports iCLK, iRST_N, iKEY_N, oLEVEL, oPRESS.
- BCD ripple increment stays inline as a combinational function.

Test Plan (sim with TICK_DIV=4, DEB_CYC=3):
- Reset then iSTART: oDIG=0x00000000. oTICK every 4th cycle; oDIG goes 0x1, 0x2 ... 0x9, then 0x10 on the 10th tick, with no oWRAP.
- Load 0x99999998 in IDLE, then iSTART: next tick gives 0x99999999, the following tick gives 0x00000000 with oWRAP=1 for exactly one cycle.
- Load 0x12345678, iMODE=1, run: ticks give 0x23456781, 0x34567812 ...; after 8 ticks oDIG=0x12345678 and oWRAP=1.
- Key bounce 1-0-1-0 with 2-cycle widths, then held low 5 cycles: exactly one press, RUN->PAUSE. oDIG frozen and the prescaler holds; a second press resumes with the remaining prescaler count intact.
- In RUN hold iLOAD_VALID=1 with data 0xABCDEF01: oLOAD_READY=0 and no transfer. After pause, transfer on the first ready cycle gives oDIG=0xABCDEF01.
- iCLR asserted with iLOAD_VALID and a tick in the same cycle: oDIG=0, state IDLE, no oTICK/oWRAP, load dropped. Async iRST_N mid-run zeroes all outputs immediately.

Source files
------------

// File: rtl/seg7_run_ctrl_pkg.sv
// Shared definitions for the 8-digit display sequencer: FSM state codes,
// step-mode codes, display word geometry and the step result payload.
package seg7_run_ctrl_pkg;

    localparam int unsigned NIB_W   = 4;
    localparam int unsigned NUM_DIG = 8;
    localparam int unsigned DIG_W   = NIB_W * NUM_DIG;
    localparam int unsigned ROT_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic MODE_BCD = 1'b0;
    localparam logic MODE_ROT = 1'b1;

    // Result of one display step: new word plus carry out of the top digit.
    typedef struct packed {
        logic             carry;
        logic [DIG_W-1:0] dig;
    } step_t;

endpackage

// File: rtl/seg7_run_ctrl_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle press pulse on each accepted 1->0 transition.
//   iCLK, iRST_N : clock, async active-low reset
//   iKEY_N       : raw active-low key, asynchronous to iCLK
//   oLEVEL       : accepted (debounced) key level, 1 = released
//   oPRESS       : one-cycle pulse when the accepted level falls
module seg7_key_debounce #(
    parameter int unsigned DEB_CYC = 1_000_000
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic iKEY_N,
    output logic oLEVEL,
    output logic oPRESS
);

    localparam int unsigned CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;

    // Synchronizer idles at the released level.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= iKEY_N;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive samples that disagree with the accepted level.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            level_d = sync2_q;
            press_d = ~sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign oLEVEL = level_q;
    assign oPRESS = press_q;

endmodule

// File: rtl/seg7_run_ctrl.sv
// Display-word sequencer for SEG7_LUT_8: BCD up-counter or digit marquee,
// stepped by an internal prescaler, paused/resumed by a debounced key and
// preloadable by the host through a valid/ready handshake.
//   iCLK, iRST_N          : clock, async active-low reset
//   iKEY_PAUSE            : raw active-low run/pause button
//   iSTART, iCLR, iMODE   : start pulse, sync clear, step mode (0 BCD, 1 rotate)
//   iLOAD_VALID/DATA      : preload request and word
//   oLOAD_READY           : preload accepted this cycle (combinational)
//   oDIG                  : display word, nibble 7 = HEX7
//   oRUNNING              : state is RUN
//   oTICK, oWRAP          : step pulse, rollover/full-rotation pulse
module seg7_run_ctrl
    import seg7_run_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned DEB_CYC  = 1_000_000
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iKEY_PAUSE,
    input  logic             iSTART,
    input  logic             iCLR,
    input  logic             iMODE,
    input  logic             iLOAD_VALID,
    input  logic [DIG_W-1:0] iLOAD_DATA,
    output logic             oLOAD_READY,
    output logic [DIG_W-1:0] oDIG,
    output logic             oRUNNING,
    output logic             oTICK,
    output logic             oWRAP
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    state_e           state_q, state_d;
    logic [DIG_W-1:0] dig_q, dig_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [ROT_W-1:0] rot_q, rot_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;

    logic             key_level, key_press;
    logic             press_evt, tick_evt, load_evt;
    logic [ROT_W-1:0] rot_base;
    step_t            bcd_step;

    seg7_key_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_key (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iKEY_N (iKEY_PAUSE),
        .oLEVEL (key_level),
        .oPRESS (key_press)
    );

    // Ripple +1 from nibble 0; nibbles >= 9 (incl. A-F) roll to 0 and carry.
    function automatic step_t bcd_inc(input logic [DIG_W-1:0] d);
        step_t            r;
        logic             c;
        logic [NIB_W-1:0] n;
        c     = 1'b1;
        r.dig = d;
        for (int i = 0; i < NUM_DIG; i++) begin
            n = d[i*NIB_W +: NIB_W];
            if (c) begin
                if (n >= NIB_W'(9)) begin
                    n = '0;
                end else begin
                    n = n + NIB_W'(1);
                    c = 1'b0;
                end
            end
            r.dig[i*NIB_W +: NIB_W] = n;
        end
        r.carry = c;
        return r;
    endfunction

    assign oLOAD_READY = (state_q != ST_RUN) && !iCLR;
    assign oRUNNING    = (state_q == ST_RUN);

    // Press pulse is only meaningful once the accepted level has settled low.
    assign press_evt = key_press && !key_level;
    assign tick_evt  = (state_q == ST_RUN) && (pre_q == PRE_MAX);
    assign load_evt  = oLOAD_READY && iLOAD_VALID;
    // A mode change seen on a tick restarts the rotation count.
    assign rot_base  = (iMODE != mode_q) ? '0 : rot_q;
    assign bcd_step  = bcd_inc(dig_q);

    // Next-state: clear > load > press > tick.
    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        pre_d   = pre_q;
        rot_d   = rot_q;
        mode_d  = mode_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (iCLR) begin
            state_d = ST_IDLE;
            dig_d   = '0;
            pre_d   = '0;
            rot_d   = '0;
        end else if (load_evt) begin
            dig_d = iLOAD_DATA;
            pre_d = '0;
            rot_d = '0;
            if ((state_q == ST_PAUSE && press_evt) || (state_q == ST_IDLE && iSTART)) begin
                state_d = ST_RUN;
            end
        end else begin
            if (state_q == ST_RUN) begin
                pre_d = tick_evt ? '0 : pre_q + PRE_W'(1);
            end
            if (tick_evt) begin
                tick_d = 1'b1;
                mode_d = iMODE;
                if (iMODE == MODE_ROT) begin
                    dig_d  = {dig_q[DIG_W-NIB_W-1:0], dig_q[DIG_W-1 -: NIB_W]};
                    rot_d  = rot_base + ROT_W'(1);
                    wrap_d = (rot_base == '1);
                end else begin
                    dig_d  = bcd_step.dig;
                    rot_d  = rot_base;
                    wrap_d = bcd_step.carry;
                end
            end
            case (state_q)
                ST_IDLE:  if (iSTART)    state_d = ST_RUN;
                ST_RUN:   if (press_evt) state_d = ST_PAUSE;
                ST_PAUSE: if (press_evt) state_d = ST_RUN;
                default:                 state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= ST_IDLE;
            dig_q   <= '0;
            pre_q   <= '0;
            rot_q   <= '0;
            mode_q  <= MODE_BCD;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            pre_q   <= pre_d;
            rot_q   <= rot_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign oDIG  = dig_q;
    assign oTICK = tick_q;
    assign oWRAP = wrap_q;

endmodule

// File: tb/tb_seg7_run_ctrl.sv
// Self-checking bench for seg7_run_ctrl with TICK_DIV=4, DEB_CYC=3:
// directed scenarios followed by randomized traffic, all against a
// behavioural model of the display sequencer.
module tb_seg7_run_ctrl;

    localparam int unsigned TD  = 4;
    localparam int unsigned DEB = 3;

    logic        iCLK = 1'b0;
    logic        iRST_N, iKEY_PAUSE, iSTART, iCLR, iMODE, iLOAD_VALID;
    logic [31:0] iLOAD_DATA;
    logic        oLOAD_READY, oRUNNING, oTICK, oWRAP;
    logic [31:0] oDIG;

    seg7_run_ctrl #(.TICK_DIV(TD), .DEB_CYC(DEB)) dut (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .iKEY_PAUSE  (iKEY_PAUSE),
        .iSTART      (iSTART),
        .iCLR        (iCLR),
        .iMODE       (iMODE),
        .iLOAD_VALID (iLOAD_VALID),
        .iLOAD_DATA  (iLOAD_DATA),
        .oLOAD_READY (oLOAD_READY),
        .oDIG        (oDIG),
        .oRUNNING    (oRUNNING),
        .oTICK       (oTICK),
        .oWRAP       (oWRAP)
    );

    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: 0 idle, 1 run, 2 pause.
    int          m_st, m_pre, m_rc;
    logic [31:0] m_dig;
    logic        m_mode, m_tick, m_wrap;
    logic        m_s1, m_s2, m_lvl, m_press;
    bit          hist[$];

    task automatic model_reset();
        m_st = 0; m_pre = 0; m_rc = 0; m_dig = '0;
        m_mode = 1'b0; m_tick = 1'b0; m_wrap = 1'b0;
        m_s1 = 1'b1; m_s2 = 1'b1; m_lvl = 1'b1; m_press = 1'b0;
        hist.delete();
    endtask

    function automatic bit all_bcd(input logic [31:0] d);
        for (int i = 0; i < 8; i++) if (((d >> (4*i)) & 32'hF) > 9) return 1'b0;
        return 1'b1;
    endfunction

    // +1 on the display word; returns {carry_out, word}.
    function automatic logic [32:0] next_count(input logic [31:0] d);
        longint      v;
        logic [31:0] r;
        if (all_bcd(d)) begin
            v = 0;
            for (int i = 7; i >= 0; i--) v = v * 10 + longint'((d >> (4*i)) & 32'hF);
            v = (v + 1) % 100000000;
            r = '0;
            for (int i = 0; i < 8; i++) begin
                r = r | (32'(v % 10) << (4*i));
                v = v / 10;
            end
            return {r == 32'h0, r};
        end
        // Lowest digit below 9 absorbs the +1, every digit under it resets.
        r = d;
        for (int i = 0; i < 8; i++) begin
            if (((r >> (4*i)) & 32'hF) < 9) begin
                r = r + (32'h1 << (4*i));
                return {1'b0, r};
            end
            r = r & ~(32'hF << (4*i));
        end
        return {1'b1, r};
    endfunction

    task automatic model_edge();
        bit          press_ev, tick_ev, ready, newp, flip;
        logic [32:0] nc;
        press_ev = m_press && !m_lvl;
        tick_ev  = (m_st == 1) && (m_pre == TD - 1);
        ready    = (m_st != 1) && !iCLR;
        m_tick = 1'b0; m_wrap = 1'b0;
        if (iCLR) begin
            m_st = 0; m_dig = '0; m_pre = 0; m_rc = 0;
        end else if (ready && iLOAD_VALID) begin
            m_dig = iLOAD_DATA; m_pre = 0; m_rc = 0;
            if ((m_st == 2 && press_ev) || (m_st == 0 && iSTART)) m_st = 1;
        end else begin
            if (m_st == 1) m_pre = tick_ev ? 0 : m_pre + 1;
            if (tick_ev) begin
                m_tick = 1'b1;
                if (iMODE != m_mode) m_rc = 0;
                m_mode = iMODE;
                if (iMODE) begin
                    m_dig  = (m_dig << 4) | (m_dig >> 28);
                    m_rc   = (m_rc + 1) % 8;
                    m_wrap = (m_rc == 0);
                end else begin
                    nc     = next_count(m_dig);
                    m_dig  = nc[31:0];
                    m_wrap = nc[32];
                end
            end
            if (m_st == 0 && iSTART) m_st = 1;
            else if (m_st == 1 && press_ev) m_st = 2;
            else if (m_st == 2 && press_ev) m_st = 1;
        end
        // Key path: accept after DEB synced samples all opposing the level.
        hist.push_back(m_s2);
        if (hist.size() > DEB) void'(hist.pop_front());
        newp = 1'b0;
        if (hist.size() == DEB) begin
            flip = 1'b1;
            foreach (hist[k]) if (hist[k] == m_lvl) flip = 1'b0;
            if (flip) begin
                m_lvl = !m_lvl;
                newp  = !m_lvl;
            end
        end
        m_press = newp;
        m_s2 = m_s1;
        m_s1 = iKEY_PAUSE;
    endtask

    task automatic cyc();
        #1;
        chk("ready", 32'(oLOAD_READY), 32'((m_st != 1) && !iCLR));
        @(posedge iCLK);
        model_edge();
        #1;
        chk("dig", oDIG, m_dig);
        chk("tick", 32'(oTICK), 32'(m_tick));
        chk("wrap", 32'(oWRAP), 32'(m_wrap));
        chk("running", 32'(oRUNNING), 32'(m_st == 1));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic pulse_start();
        iSTART = 1'b1; cyc(); iSTART = 1'b0;
    endtask

    task automatic pulse_clr();
        iCLR = 1'b1; cyc(); iCLR = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] d);
        iLOAD_VALID = 1'b1; iLOAD_DATA = d; cyc(); iLOAD_VALID = 1'b0;
    endtask

    task automatic key_seq(input int low_cyc);
        iKEY_PAUSE = 1'b0; cycles(low_cyc); iKEY_PAUSE = 1'b1;
    endtask

    initial begin
        iRST_N = 1'b0; iKEY_PAUSE = 1'b1; iSTART = 1'b0; iCLR = 1'b0;
        iMODE = 1'b0; iLOAD_VALID = 1'b0; iLOAD_DATA = '0;
        model_reset();
        repeat (2) @(posedge iCLK);
        #1;
        chk("rst_dig", oDIG, 32'h0);
        chk("rst_run", 32'(oRUNNING), 32'h0);
        chk("rst_tick", 32'(oTICK | oWRAP), 32'h0);
        chk("rst_ready", 32'(oLOAD_READY), 32'h1);
        iRST_N = 1'b1;

        // BCD count from zero: ten steps reach 0x10.
        pulse_start();
        cycles(40);
        chk("bcd_10", oDIG, 32'h10);

        // Rollover of 99999999.
        pulse_clr();
        load_word(32'h99999998);
        pulse_start();
        cycles(8);
        chk("roll_dig", oDIG, 32'h0);
        chk("roll_wrap", 32'(oWRAP), 32'h1);
        cycles(2);

        // Marquee: eight steps return the word with a wrap pulse.
        pulse_clr();
        iMODE = 1'b1;
        load_word(32'h12345678);
        pulse_start();
        cycles(4);
        chk("rot_1", oDIG, 32'h23456781);
        cycles(28);
        chk("rot_8", oDIG, 32'h12345678);
        chk("rot_wrap", 32'(oWRAP), 32'h1);

        // Bounce then a real press pauses; second press resumes.
        iMODE = 1'b0;
        for (int b = 0; b < 2; b++) begin
            iKEY_PAUSE = 1'b0; cycles(2);
            iKEY_PAUSE = 1'b1; cycles(2);
        end
        chk("bounce_run", 32'(oRUNNING), 32'h1);
        key_seq(5);
        cycles(8);
        chk("paused", 32'(oRUNNING), 32'h0);
        cycles(10);
        key_seq(5);
        cycles(12);
        chk("resumed", 32'(oRUNNING), 32'h1);

        // Load held off while running, taken once paused.
        iLOAD_VALID = 1'b1; iLOAD_DATA = 32'hABCDEF01;
        cycles(6);
        key_seq(5);
        cycles(10);
        iLOAD_VALID = 1'b0;
        chk("held_load", oDIG, 32'hABCDEF01);
        key_seq(5);
        cycles(10);

        // Clear wins over a coincident load and tick.
        begin
            int k = 0;
            while (!(m_st == 1 && m_pre == TD - 1) && k < 16) begin
                cyc(); k++;
            end
            chk("tick_found", 32'(k < 16), 32'h1);
        end
        iCLR = 1'b1; iLOAD_VALID = 1'b1; iLOAD_DATA = 32'h55555555;
        cyc();
        iCLR = 1'b0; iLOAD_VALID = 1'b0;
        chk("clr_dig", oDIG, 32'h0);
        chk("clr_tick", 32'(oTICK), 32'h0);

        // Asynchronous reset mid-run.
        pulse_start();
        cycles(9);
        @(posedge iCLK);
        #3 iRST_N = 1'b0;
        #1;
        chk("arst_dig", oDIG, 32'h0);
        chk("arst_run", 32'(oRUNNING), 32'h0);
        chk("arst_pulse", 32'(oTICK | oWRAP), 32'h0);
        model_reset();
        @(posedge iCLK);
        #1 iRST_N = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            iCLR        = ($urandom_range(63) == 0);
            iSTART      = ($urandom_range(15) == 0);
            if ($urandom_range(31) == 0) iMODE = ~iMODE;
            if ($urandom_range(5) == 0) iKEY_PAUSE = ~iKEY_PAUSE;
            iLOAD_VALID = ($urandom_range(3) == 0);
            case ($urandom_range(3))
                0:       iLOAD_DATA = $urandom();
                1:       iLOAD_DATA = 32'h99999990 | 32'($urandom_range(9));
                default: iLOAD_DATA = 32'h01234567 + 32'($urandom_range(3));
            endcase
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
